// File: rtl/mem_port_scheduler.sv
// Arbitrates the CPU instruction and data ports onto one memory port.
// Within a scheduling round the data side is always served before the instruction side.
module mem_port_scheduler #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cs,
  input  logic              i_oe,
  input  logic [3:0]        i_web,
  input  logic [ADDR_W-1:0] i_address,
  input  logic [DATA_W-1:0] i_di,
  output logic [DATA_W-1:0] i_do,
  output logic              i_stall,
  input  logic              d_cs,
  input  logic              d_oe,
  input  logic [3:0]        d_web,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_di,
  output logic [DATA_W-1:0] d_do,
  output logic              d_stall,
  output logic              m_req,
  output logic              m_write,
  output logic [3:0]        m_wstrb,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ready,
  input  logic [DATA_W-1:0] m_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_D  = 2'd1,
    BUSY_I  = 2'd2,
    RELEASE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              pd_q, pd_d;
  logic              pi_q, pi_d;
  logic [ADDR_W-1:0] i_addr_q, i_addr_d;
  logic [ADDR_W-1:0] d_addr_q, d_addr_d;
  logic [DATA_W-1:0] d_wdata_q, d_wdata_d;
  logic [3:0]        d_web_q, d_web_d;
  logic [DATA_W-1:0] i_do_q, i_do_d;
  logic [DATA_W-1:0] d_do_q, d_do_d;

  logic i_req, d_req, d_wr;
  logic unused_inputs;

  // The instruction port is read-only, so its write data and strobes are dropped.
  assign unused_inputs = ^{i_di, i_web};

  assign i_req = i_cs & i_oe;
  assign d_wr  = (d_web != 4'hF);
  assign d_req = d_cs & (d_oe | d_wr);

  // Memory handshake: m_req and the m_* payload are pure functions of registered
  // state and stay constant while m_req is high; a transfer completes in the cycle
  // m_ready is sampled high with m_req high, and m_ready is ignored otherwise.
  always_comb begin
    m_req   = (state_q == BUSY_D) || (state_q == BUSY_I);
    m_write = 1'b0;
    m_wstrb = '0;
    m_addr  = '0;
    m_wdata = '0;
    case (state_q)
      BUSY_D: begin
        m_write = (d_web_q != 4'hF);
        m_wstrb = ~d_web_q;
        m_addr  = d_addr_q;
        m_wdata = d_wdata_q;
      end
      BUSY_I:  m_addr = i_addr_q;
      default: ;
    endcase
  end

  assign i_stall = i_req & (state_q != RELEASE);
  assign d_stall = d_req & (state_q != RELEASE);
  assign i_do    = i_do_q;
  assign d_do    = d_do_q;

  always_comb begin
    state_d   = state_q;
    pd_d      = pd_q;
    pi_d      = pi_q;
    i_addr_d  = i_addr_q;
    d_addr_d  = d_addr_q;
    d_wdata_d = d_wdata_q;
    d_web_d   = d_web_q;
    i_do_d    = i_do_q;
    d_do_d    = d_do_q;
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          pd_d      = d_req;
          pi_d      = i_req;
          i_addr_d  = i_address;
          d_addr_d  = d_address;
          d_wdata_d = d_di;
          d_web_d   = d_web;
          state_d   = d_req ? BUSY_D : BUSY_I;
        end
      end
      BUSY_D: begin
        if (m_ready) begin
          if (d_web_q == 4'hF) d_do_d = m_rdata;
          pd_d    = 1'b0;
          state_d = pi_q ? BUSY_I : RELEASE;
        end
      end
      BUSY_I: begin
        if (m_ready) begin
          i_do_d  = m_rdata;
          pi_d    = 1'b0;
          state_d = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      pd_q      <= 1'b0;
      pi_q      <= 1'b0;
      i_addr_q  <= '0;
      d_addr_q  <= '0;
      d_wdata_q <= '0;
      d_web_q   <= '0;
      i_do_q    <= '0;
      d_do_q    <= '0;
    end else begin
      state_q   <= state_d;
      pd_q      <= pd_d;
      pi_q      <= pi_d;
      i_addr_q  <= i_addr_d;
      d_addr_q  <= d_addr_d;
      d_wdata_q <= d_wdata_d;
      d_web_q   <= d_web_d;
      i_do_q    <= i_do_d;
      d_do_q    <= d_do_d;
    end
  end

endmodule
